// File: rtl/lint_apb_rr_arbiter.sv
// Round-robin arbiter funnelling N lint masters into a single lint-to-APB bridge port.
// One transaction is outstanding at a time; the response is routed back to the owner.
module lint_apb_rr_arbiter #(
    parameter int N_MASTER   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            in_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] in_add_i,
    input  logic [N_MASTER-1:0]            in_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] in_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   in_be_i,
    output logic [N_MASTER-1:0]            in_gnt_o,
    output logic [N_MASTER-1:0]            in_r_valid_o,
    output logic [DATA_WIDTH-1:0]          in_r_rdata_o,
    output logic                           in_r_opc_o,
    output logic                           out_req_o,
    output logic [ADDR_WIDTH-1:0]          out_add_o,
    output logic                           out_wen_o,
    output logic [DATA_WIDTH-1:0]          out_wdata_o,
    output logic [BE_WIDTH-1:0]            out_be_o,
    output logic [ID_WIDTH-1:0]            out_ID_o,
    input  logic                           out_gnt_i,
    input  logic                           out_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          out_r_rdata_i,
    input  logic                           out_r_opc_i,
    input  logic [ID_WIDTH-1:0]            out_r_ID_i,
    output logic                           err_id_o
);

    localparam int IDX_W = $clog2(N_MASTER);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel;
    logic             win_valid;
    logic             gnt_fire;
    logic             resp_fire;
    logic             fwd;

    // Modulo-N addition that also works when N_MASTER is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= (IDX_W+1)'(N_MASTER)) begin
            s = s - (IDX_W+1)'(N_MASTER);
        end
        return s[IDX_W-1:0];
    endfunction

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            cand = wrap_add(rr_q, IDX_W'(i));
            if (!win_valid && in_req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Only IDLE arbitrates; HOLD and WAIT_RESP stay locked on the owner.
    assign sel       = (state_q == IDLE) ? win_idx : owner_q;
    assign gnt_fire  = out_gnt_i && (((state_q == IDLE) && win_valid) ||
                                     ((state_q == HOLD) && in_req_i[owner_q]));
    assign resp_fire = (state_q == WAIT_RESP) && out_r_valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = out_gnt_i ? WAIT_RESP : HOLD;
                end
            end
            HOLD: begin
                if (!in_req_i[owner_q]) begin
                    state_d = IDLE;
                end else if (out_gnt_i) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (out_r_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= '0;
            rr_q     <= '0;
            err_id_o <= 1'b0;
        end else begin
            if ((state_q == IDLE) && win_valid) begin
                owner_q <= win_idx;
            end
            if (gnt_fire) begin
                rr_q <= wrap_add(sel, IDX_W'(1));
            end
            // A mismatched ID is flagged but the response still goes to the owner.
            if (resp_fire && (out_r_ID_i != ID_WIDTH'(owner_q))) begin
                err_id_o <= 1'b1;
            end
        end
    end

    always_comb begin
        fwd          = (state_q == IDLE) ? win_valid : 1'b1;
        out_add_o    = '0;
        out_wen_o    = 1'b1;
        out_wdata_o  = '0;
        out_be_o     = '0;
        out_ID_o     = '0;
        if (fwd) begin
            out_add_o   = in_add_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
            out_wen_o   = in_wen_i[sel];
            out_wdata_o = in_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            out_be_o    = in_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
            out_ID_o    = ID_WIDTH'(sel);
        end
        out_req_o    = ((state_q == IDLE) && win_valid) ||
                       ((state_q == HOLD) && in_req_i[owner_q]);
        in_gnt_o     = gnt_fire ? (N_MASTER'(1) << sel) : '0;
        in_r_valid_o = resp_fire ? (N_MASTER'(1) << owner_q) : '0;
        in_r_rdata_o = resp_fire ? out_r_rdata_i : '0;
        in_r_opc_o   = resp_fire ? out_r_opc_i : 1'b0;
    end

endmodule
